// File: rtl/regfile_pkg.sv
// Shared widths, the zero-register index and address/data types for the
// multi-port register file.
package regfile_pkg;
  localparam int N_DEFAULT = 32;
  localparam int R_DEFAULT = 5;
  localparam int ZERO_REG  = 0;

  typedef logic [R_DEFAULT-1:0] reg_addr_t;
  typedef logic [N_DEFAULT-1:0] reg_data_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard.
// Issue sets a busy bit, writeback clears it, and each read port looks up its busy bit.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int r      = R_DEFAULT,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               set_en,
  input  logic [r-1:0]       set_add,
  input  logic               clr_a,
  input  logic [r-1:0]       clr_a_add,
  input  logic               clr_b,
  input  logic [r-1:0]       clr_b_add,
  input  logic [NREAD*r-1:0] read_add,
  output logic [NREAD-1:0]   read_busy,
  output logic [2**r-1:0]    busy_vec
);
  localparam int DEPTH = 2**r;
  localparam logic [r-1:0] ZERO_ADDR = r'(ZERO_REG);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // A new issue to the same register outranks an older writeback on one edge.
  always_comb begin
    busy_d = busy_q;
    if (clr_a) busy_d[clr_a_add] = 1'b0;
    if (clr_b) busy_d[clr_b_add] = 1'b0;
    if (set_en && (set_add != ZERO_ADDR)) busy_d[set_add] = 1'b1;
    busy_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rb
    logic [r-1:0] ra;
    logic         fwd_hit;
    assign ra      = read_add[i*r +: r];
    assign fwd_hit = (BYPASS != 0) &&
                     ((clr_a && (clr_a_add == ra)) || (clr_b && (clr_b_add == ra)));
    assign read_busy[i] = busy_q[ra] & ~fwd_hit;
  end

  assign busy_vec = busy_q;
endmodule

// File: rtl/regfile_mp.sv
// Decode-stage register file: NREAD combinational read ports, ALU (A) and load (B)
// write ports with B priority, optional write-through bypass and a busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int n      = N_DEFAULT,
  parameter int r      = R_DEFAULT,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we_a,
  input  logic [r-1:0]       wadd_a,
  input  logic [n-1:0]       wdata_a,
  input  logic               we_b,
  input  logic [r-1:0]       wadd_b,
  input  logic [n-1:0]       wdata_b,
  input  logic [NREAD*r-1:0] read_add,
  output logic [NREAD*n-1:0] read_data,
  output logic [NREAD-1:0]   read_busy,
  input  logic               set_en,
  input  logic [r-1:0]       set_add,
  output logic [2**r-1:0]    busy_vec,
  output logic               wr_conflict
);
  localparam int DEPTH = 2**r;
  localparam logic [r-1:0] ZERO_ADDR = r'(ZERO_REG);

  logic [n-1:0] regs_q [DEPTH];
  logic [n-1:0] regs_d [DEPTH];
  logic         wr_conflict_q, wr_conflict_d;
  logic         wr_a_ok, wr_b_ok;

  assign wr_a_ok = we_a && (wadd_a != ZERO_ADDR);
  assign wr_b_ok = we_b && (wadd_b != ZERO_ADDR);
  assign wr_conflict_d = wr_a_ok && wr_b_ok && (wadd_a == wadd_b);

  // Port B is applied last so the load result wins a same-address collision.
  always_comb begin
    regs_d = regs_q;
    if (wr_a_ok) regs_d[wadd_a] = wdata_a;
    if (wr_b_ok) regs_d[wadd_b] = wdata_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) regs_q[k] <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      regs_q        <= regs_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  assign wr_conflict = wr_conflict_q;

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [r-1:0] ra;
    logic [n-1:0] rd;
    assign ra = read_add[i*r +: r];

    // Reset also masks forwarded data so nothing leaks out while rst_n is low.
    always_comb begin
      rd = regs_q[ra];
      if (BYPASS != 0) begin
        if (wr_a_ok && (wadd_a == ra)) rd = wdata_a;
        if (wr_b_ok && (wadd_b == ra)) rd = wdata_b;
      end
      if (!rst_n || (ra == ZERO_ADDR)) rd = '0;
    end

    assign read_data[i*n +: n] = rd;
  end

  regfile_scoreboard #(
    .r      (r),
    .NREAD  (NREAD),
    .BYPASS (BYPASS)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en    (set_en),
    .set_add   (set_add),
    .clr_a     (wr_a_ok),
    .clr_a_add (wadd_a),
    .clr_b     (wr_b_ok),
    .clr_b_add (wadd_b),
    .read_add  (read_add),
    .read_busy (read_busy),
    .busy_vec  (busy_vec)
  );
endmodule

// File: tb/tb_regfile_mp.sv
// Randomized bench for regfile_mp: a BYPASS=1 and a BYPASS=0 instance share stimulus
// and are compared against an array-based reference model.
module tb_regfile_mp;
  localparam int N  = 32;
  localparam int R  = 5;
  localparam int NR = 2;
  localparam int D  = 2**R;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          we_a, we_b, set_en;
  logic [R-1:0]  wadd_a, wadd_b, set_add;
  logic [N-1:0]  wdata_a, wdata_b;
  logic [NR*R-1:0] read_add;
  logic [NR*N-1:0] rd_byp, rd_nob;
  logic [NR-1:0] rb_byp, rb_nob;
  logic [D-1:0]  bv_byp, bv_nob;
  logic          wc_byp, wc_nob;

  int n_vec = 0;
  int n_err = 0;

  logic [N-1:0] m_reg [D];
  bit           m_busy [D];
  bit           m_conf;

  regfile_mp #(.n(N), .r(R), .NREAD(NR), .BYPASS(1)) dut_byp (
    .clk(clk), .rst_n(rst_n),
    .we_a(we_a), .wadd_a(wadd_a), .wdata_a(wdata_a),
    .we_b(we_b), .wadd_b(wadd_b), .wdata_b(wdata_b),
    .read_add(read_add), .read_data(rd_byp), .read_busy(rb_byp),
    .set_en(set_en), .set_add(set_add), .busy_vec(bv_byp), .wr_conflict(wc_byp)
  );

  regfile_mp #(.n(N), .r(R), .NREAD(NR), .BYPASS(0)) dut_nob (
    .clk(clk), .rst_n(rst_n),
    .we_a(we_a), .wadd_a(wadd_a), .wdata_a(wdata_a),
    .we_b(we_b), .wadd_b(wadd_b), .wdata_b(wdata_b),
    .read_add(read_add), .read_data(rd_nob), .read_busy(rb_nob),
    .set_en(set_en), .set_add(set_add), .busy_vec(bv_nob), .wr_conflict(wc_nob)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void m_clear();
    for (int k = 0; k < D; k++) begin
      m_reg[k]  = '0;
      m_busy[k] = 1'b0;
    end
    m_conf = 1'b0;
  endfunction

  function automatic bit wr_hits(input logic [R-1:0] a);
    return (we_a && wadd_a != 0 && wadd_a == a) || (we_b && wadd_b != 0 && wadd_b == a);
  endfunction

  function automatic logic [N-1:0] m_read(input logic [R-1:0] a, input bit byp);
    if (!rst_n || a == 0) return '0;
    if (byp && we_b && wadd_b == a) return wdata_b;
    if (byp && we_a && wadd_a == a) return wdata_a;
    return m_reg[a];
  endfunction

  function automatic logic [D-1:0] m_bvec();
    logic [D-1:0] v = '0;
    for (int k = 0; k < D; k++) v[k] = m_busy[k];
    return v;
  endfunction

  // Edge semantics straight from the rules: B overwrites A, set beats clear, r0 inert.
  function automatic void m_edge();
    bit conf = we_a && we_b && (wadd_a == wadd_b) && (wadd_a != 0);
    if (we_a && wadd_a != 0) begin m_reg[wadd_a] = wdata_a; m_busy[wadd_a] = 1'b0; end
    if (we_b && wadd_b != 0) begin m_reg[wadd_b] = wdata_b; m_busy[wadd_b] = 1'b0; end
    if (set_en && set_add != 0) m_busy[set_add] = 1'b1;
    m_conf = conf;
  endfunction

  task automatic check_all();
    logic [R-1:0] a;
    for (int i = 0; i < NR; i++) begin
      a = read_add[i*R +: R];
      chk($sformatf("rd%0d_byp[a=%0d]", i, a), rd_byp[i*N +: N], m_read(a, 1'b1));
      chk($sformatf("rd%0d_nob[a=%0d]", i, a), rd_nob[i*N +: N], m_read(a, 1'b0));
      chk($sformatf("rbusy%0d_byp[a=%0d]", i, a), rb_byp[i],
          rst_n && m_busy[a] && !wr_hits(a));
      chk($sformatf("rbusy%0d_nob[a=%0d]", i, a), rb_nob[i], rst_n && m_busy[a]);
    end
    chk("busy_vec_byp", bv_byp, m_bvec());
    chk("busy_vec_nob", bv_nob, m_bvec());
    chk("wr_conflict_byp", wc_byp, m_conf);
    chk("wr_conflict_nob", wc_nob, m_conf);
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    #1 check_all();
    @(posedge clk);
    if (rst_n) m_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    we_a = 0; we_b = 0; set_en = 0;
    wadd_a = '0; wadd_b = '0; set_add = '0;
    wdata_a = '0; wdata_b = '0;
  endtask

  task automatic rd(input logic [R-1:0] a0, input logic [R-1:0] a1);
    read_add = {a1, a0};
  endtask

  initial begin
    idle();
    rd(0, 0);
    m_clear();
    #1 rst_n = 1'b0;
    m_clear();

    // Reset held while a write is requested.
    @(negedge clk);
    we_a = 1; wadd_a = 3; wdata_a = 32'hDEADBEEF; rd(3, 3);
    step(); step();
    idle(); rst_n = 1'b1; rd(3, 0);
    step();
    chk("reset_reg3", rd_byp[N-1:0], 32'h0);

    // Dual write, distinct addresses.
    we_a = 1; wadd_a = 5; wdata_a = 32'h11111111;
    we_b = 1; wadd_b = 6; wdata_b = 32'h22222222;
    step();
    idle(); rd(5, 6);
    step();

    // Collision: B wins, conflict visible for exactly one cycle.
    we_a = 1; wadd_a = 7; wdata_a = 32'hAAAA0000;
    we_b = 1; wadd_b = 7; wdata_b = 32'hBBBB0000;
    rd(7, 7);
    step();
    idle();
    #1 chk("conflict_set", wc_byp, 1'b1);
    #0 step();
    step();

    // Bypass with a busy register.
    set_en = 1; set_add = 9; rd(0, 9);
    step();
    idle(); we_a = 1; wadd_a = 9; wdata_a = 32'h12345678; rd(0, 9);
    step();
    idle(); rd(0, 9);
    step();

    // Zero register.
    we_b = 1; wadd_b = 0; wdata_b = 32'hFFFFFFFF; set_en = 1; set_add = 0; rd(0, 0);
    step();
    idle();
    step();

    // Scoreboard race, then async reset in the middle of the sequence.
    set_en = 1; set_add = 4; rd(4, 4);
    step();
    idle(); rd(4, 4);
    step();
    we_a = 1; wadd_a = 4; wdata_a = 32'h0A0A0A0A; set_en = 1; set_add = 4;
    step();
    idle(); we_a = 1; wadd_a = 4; wdata_a = 32'h0B0B0B0B;
    step();
    idle(); set_en = 1; set_add = 4;
    step();
    idle(); we_b = 1; wadd_b = 12; wdata_b = 32'h5555AAAA; set_en = 1; set_add = 12;
    #2 rst_n = 1'b0;
    m_clear();
    step();
    rst_n = 1'b1; idle(); we_a = 1; wadd_a = 4; wdata_a = 32'hCAFEF00D; rd(4, 12);
    step();
    idle(); rd(4, 12);
    step();

    // Randomized traffic over a small address window to provoke hazards.
    for (int c = 0; c < 400; c++) begin
      logic [R-1:0] a0, a1;
      we_a    = 1'($urandom);
      we_b    = 1'($urandom);
      set_en  = 1'($urandom);
      wadd_a  = ($urandom % 4 == 0) ? R'($urandom) : R'($urandom_range(0, 7));
      wadd_b  = ($urandom % 4 == 0) ? R'($urandom) : R'($urandom_range(0, 7));
      set_add = R'($urandom_range(0, 7));
      wdata_a = $urandom;
      wdata_b = $urandom;
      a0 = ($urandom % 3 == 0) ? wadd_a : R'($urandom_range(0, 7));
      a1 = ($urandom % 3 == 0) ? wadd_b : R'($urandom_range(0, 7));
      rd(a0, a1);
      if ($urandom % 64 == 0) begin
        rst_n = 1'b0;
        m_clear();
      end else begin
        rst_n = 1'b1;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
